// File: rtl/pc_gen_if.sv
// Fetch-address generator bus: event inputs from branch/exception logic,
// fetch address and return-stack status back out.
//   master: stall, trap, redirect_valid/addr, call_valid/target, ret_valid -> ;
//           <- pc, pc_seq, ras_count, ras_miss
//   slave : mirror of master (used by pc_gen)
interface pc_gen_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CW = $clog2(RAS_DEPTH) + 1;

  logic            stall;
  logic            trap;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_addr;
  logic            call_valid;
  logic [XLEN-1:0] call_target;
  logic            ret_valid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_seq;
  logic [CW-1:0]   ras_count;
  logic            ras_miss;

  modport master (
    output stall, trap, redirect_valid, redirect_addr,
           call_valid, call_target, ret_valid,
    input  pc, pc_seq, ras_count, ras_miss
  );

  modport slave (
    input  stall, trap, redirect_valid, redirect_addr,
           call_valid, call_target, ret_valid,
    output pc, pc_seq, ras_count, ras_miss
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC register with prioritised next-PC selection (trap, redirect,
// call/return via a circular return-address stack, stall, sequential).
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   io_bus : pc_gen_if.slave -- events in; pc (registered), pc_seq (comb),
//            ras_count / ras_miss (registered) out
module pc_gen #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(32'h0000_0100),
  parameter int unsigned     INSTR_BYTES = 4,
  parameter int unsigned     RAS_DEPTH   = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.slave  io_bus
);
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));

  function automatic logic [XLEN-1:0] align_addr(input logic [XLEN-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_ptr;     // next free slot; top entry is r_ptr-1
  logic            r_miss;
  logic [XLEN-1:0] r_ras [RAS_DEPTH];

  logic [XLEN-1:0] w_pc_seq;
  logic [PW-1:0]   w_top_idx;
  logic [XLEN-1:0] w_pc_next;
  logic [CW-1:0]   w_count_next;
  logic [PW-1:0]   w_ptr_next;
  logic            w_miss_next;
  logic            w_wr_en;
  logic [PW-1:0]   w_wr_idx;

  assign w_pc_seq  = r_pc + XLEN'(INSTR_BYTES);
  assign w_top_idx = r_ptr - PW'(1);

  // Next-PC / RAS decision, highest priority first
  always_comb begin
    w_pc_next    = r_pc;
    w_count_next = r_count;
    w_ptr_next   = r_ptr;
    w_miss_next  = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_idx     = r_ptr;
    if (io_bus.trap) begin
      w_pc_next    = align_addr(TRAP_VEC);
      w_count_next = '0;
    end else if (io_bus.redirect_valid) begin
      w_pc_next = align_addr(io_bus.redirect_addr);
    end else if (io_bus.ret_valid && io_bus.call_valid) begin
      // Tail call: swap the top return address instead of pop+push
      w_pc_next = align_addr(io_bus.call_target);
      w_wr_en   = 1'b1;
      if (r_count == '0) begin
        w_wr_idx     = r_ptr;
        w_ptr_next   = r_ptr + PW'(1);
        w_count_next = CW'(1);
        w_miss_next  = 1'b1;
      end else begin
        w_wr_idx = w_top_idx;
      end
    end else if (io_bus.ret_valid) begin
      if (r_count != '0) begin
        w_pc_next    = r_ras[w_top_idx];
        w_ptr_next   = w_top_idx;
        w_count_next = r_count - CW'(1);
      end else begin
        w_pc_next   = w_pc_seq;
        w_miss_next = 1'b1;
      end
    end else if (io_bus.call_valid) begin
      // Push on full overwrites the oldest slot; count saturates
      w_pc_next  = align_addr(io_bus.call_target);
      w_wr_en    = 1'b1;
      w_ptr_next = r_ptr + PW'(1);
      if (r_count != CW'(RAS_DEPTH)) w_count_next = r_count + CW'(1);
    end else if (!io_bus.stall) begin
      w_pc_next = w_pc_seq;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= align_addr(RESET_VEC);
      r_count <= '0;
      r_ptr   <= '0;
      r_miss  <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_count <= w_count_next;
      r_ptr   <= w_ptr_next;
      r_miss  <= w_miss_next;
    end
  end

  // Stack storage needs no reset; validity is tracked by r_count
  always_ff @(posedge clk) begin
    if (w_wr_en) r_ras[w_wr_idx] <= w_pc_seq;
  end

  assign io_bus.pc        = r_pc;
  assign io_bus.pc_seq    = w_pc_seq;
  assign io_bus.ras_count = r_count;
  assign io_bus.ras_miss  = r_miss;
endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;

  pc_gen_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();

  pc_gen #(
    .XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100),
    .INSTR_BYTES(4), .RAS_DEPTH(4)
  ) u_dut (
    .clk(clk), .rst(rst), .io_bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural reference: pc value plus a bounded LIFO of return addresses
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ras[$];
  logic        m_miss = 1'b0;

  task automatic model_reset();
    m_pc = 32'h0;
    m_ras.delete();
    m_miss = 1'b0;
  endtask

  task automatic model_edge(input logic st, tr, rv, input logic [31:0] ra,
                            input logic cv, input logic [31:0] ct, input logic rt);
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    m_miss = 1'b0;
    if (tr) begin
      m_pc = 32'h100;
      m_ras.delete();
    end else if (rv) begin
      m_pc = ra & ~32'd3;
    end else if (rt && cv) begin
      m_pc = ct & ~32'd3;
      if (m_ras.size() == 0) begin
        m_ras.push_back(seq);
        m_miss = 1'b1;
      end else begin
        m_ras[m_ras.size()-1] = seq;
      end
    end else if (rt) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        m_pc = seq;
        m_miss = 1'b1;
      end
    end else if (cv) begin
      m_pc = ct & ~32'd3;
      m_ras.push_back(seq);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end else if (!st) begin
      m_pc = seq;
    end
  endtask

  // Drive one cycle of events (from a negedge), clock it, return at next negedge
  task automatic step(input logic st, tr, rv, input logic [31:0] ra,
                      input logic cv, input logic [31:0] ct, input logic rt);
    bus.stall = st; bus.trap = tr; bus.redirect_valid = rv; bus.redirect_addr = ra;
    bus.call_valid = cv; bus.call_target = ct; bus.ret_valid = rt;
    model_edge(st, tr, rv, ra, cv, ct, rt);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
    bus.stall = 0; bus.trap = 0; bus.redirect_valid = 0; bus.redirect_addr = 0;
    bus.call_valid = 0; bus.call_target = 0; bus.ret_valid = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", bus.pc); end
    checks++; if (bus.ras_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.ras_count); end
    checks++; if (bus.ras_miss !== 1'b0) begin errors++; $display("FAIL reset_miss got=%b exp=0", bus.ras_miss); end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++; if (bus.pc !== exp_pc[i]) begin errors++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.pc, exp_pc[i]); end
    end
    checks++; if (bus.ras_count !== 3'd0) begin errors++; $display("FAIL seq_count got=%0d exp=0", bus.ras_count); end
  endtask

  task automatic test_call_ret();
    step(0, 0, 1, 32'h10, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h200, 0);
    checks++; if (bus.pc !== 32'h200) begin errors++; $display("FAIL call_pc got=%h exp=200", bus.pc); end
    checks++; if (bus.ras_count !== 3'd1) begin errors++; $display("FAIL call_count got=%0d exp=1", bus.ras_count); end
    step(0, 0, 0, 0, 0, 0, 1);
    checks++; if (bus.pc !== 32'h14) begin errors++; $display("FAIL ret_pc got=%h exp=14", bus.pc); end
    checks++; if (bus.ras_count !== 3'd0) begin errors++; $display("FAIL ret_count got=%0d exp=0", bus.ras_count); end
  endtask

  task automatic test_nested();
    logic [31:0] exp_ret [4];
    exp_ret[0] = 32'h2304; exp_ret[1] = 32'h2204; exp_ret[2] = 32'h2104; exp_ret[3] = 32'h2004;
    step(0, 0, 1, 32'h1000, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 32'h2000 + 32'(i) * 32'h100, 0);
    checks++; if (bus.ras_count !== 3'd4) begin errors++; $display("FAIL nest_count got=%0d exp=4", bus.ras_count); end
    checks++; if (bus.pc !== 32'h2400) begin errors++; $display("FAIL nest_pc got=%h exp=2400", bus.pc); end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      checks++; if (bus.pc !== exp_ret[i]) begin errors++; $display("FAIL nest_ret[%0d] got=%h exp=%h", i, bus.pc, exp_ret[i]); end
    end
    checks++; if (bus.ras_miss !== 1'b0) begin errors++; $display("FAIL nest_nomiss got=%b exp=0", bus.ras_miss); end
    step(0, 0, 0, 0, 0, 0, 1);
    checks++; if (bus.pc !== 32'h2008) begin errors++; $display("FAIL empty_ret_pc got=%h exp=2008", bus.pc); end
    checks++; if (bus.ras_miss !== 1'b1) begin errors++; $display("FAIL empty_ret_miss got=%b exp=1", bus.ras_miss); end
    checks++; if (bus.ras_count !== 3'd0) begin errors++; $display("FAIL empty_ret_count got=%0d exp=0", bus.ras_count); end
    idle();
    checks++; if (bus.ras_miss !== 1'b0) begin errors++; $display("FAIL miss_pulse got=%b exp=0", bus.ras_miss); end
  endtask

  task automatic test_stall_redirect();
    step(1, 0, 1, 32'h303, 0, 0, 0);
    checks++; if (bus.pc !== 32'h300) begin errors++; $display("FAIL stall_redir got=%h exp=300", bus.pc); end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.pc !== 32'h300) begin errors++; $display("FAIL stall_hold[%0d] got=%h exp=300", i, bus.pc); end
    end
  endtask

  task automatic test_trap();
    step(0, 0, 0, 0, 1, 32'h400, 0);
    step(0, 0, 0, 0, 1, 32'h500, 0);
    checks++; if (bus.ras_count !== 3'd2) begin errors++; $display("FAIL pretrap_count got=%0d exp=2", bus.ras_count); end
    step(0, 1, 1, 32'h700, 1, 32'h800, 0);
    checks++; if (bus.pc !== 32'h100) begin errors++; $display("FAIL trap_pc got=%h exp=100", bus.pc); end
    checks++; if (bus.ras_count !== 3'd0) begin errors++; $display("FAIL trap_count got=%0d exp=0", bus.ras_count); end
    idle();
    checks++; if (bus.pc !== 32'h104) begin errors++; $display("FAIL posttrap_pc got=%h exp=104", bus.pc); end
    checks++; if (bus.ras_count !== 3'd0) begin errors++; $display("FAIL posttrap_count got=%0d exp=0", bus.ras_count); end
  endtask

  task automatic test_tail_call();
    step(0, 0, 0, 0, 1, 32'hA01, 1);
    checks++; if (bus.pc !== 32'hA00) begin errors++; $display("FAIL tail_empty_pc got=%h exp=a00", bus.pc); end
    checks++; if (bus.ras_miss !== 1'b1) begin errors++; $display("FAIL tail_empty_miss got=%b exp=1", bus.ras_miss); end
    checks++; if (bus.ras_count !== 3'd1) begin errors++; $display("FAIL tail_empty_count got=%0d exp=1", bus.ras_count); end
    step(0, 0, 0, 0, 1, 32'hB00, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    checks++; if (bus.pc !== 32'hA04) begin errors++; $display("FAIL tail_ret_pc got=%h exp=a04", bus.pc); end
  endtask

  task automatic test_wrap();
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    checks++; if (bus.pc_seq !== 32'h0) begin errors++; $display("FAIL wrap_seq got=%h exp=0", bus.pc_seq); end
    idle();
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=0", bus.pc); end
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0, 0, 1, 32'h800, 0);
    bus.call_valid = 1'b1; bus.call_target = 32'h900;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL async_rst_pc got=%h exp=0", bus.pc); end
    checks++; if (bus.ras_count !== 3'd0) begin errors++; $display("FAIL async_rst_count got=%0d exp=0", bus.ras_count); end
    @(posedge clk);
    @(negedge clk);
    bus.call_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    idle();
    checks++; if (bus.pc !== 32'h4) begin errors++; $display("FAIL post_rst_pc got=%h exp=4", bus.pc); end
  endtask

  task automatic test_random();
    logic st, tr, rv, cv, rt;
    logic [31:0] ra, ct;
    for (int n = 0; n < 400; n++) begin
      st = ($urandom_range(3) == 0);
      tr = ($urandom_range(31) == 0);
      rv = ($urandom_range(7) == 0);
      cv = ($urandom_range(3) == 0);
      rt = ($urandom_range(3) == 0);
      ra = $urandom;
      ct = $urandom;
      step(st, tr, rv, ra, cv, ct, rt);
      checks++; if (bus.pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", n, bus.pc, m_pc); end
      checks++; if (bus.pc_seq !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_seq[%0d] got=%h exp=%h", n, bus.pc_seq, m_pc + 32'd4); end
      checks++; if (bus.ras_count !== 3'(m_ras.size())) begin errors++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", n, bus.ras_count, m_ras.size()); end
      checks++; if (bus.ras_miss !== m_miss) begin errors++; $display("FAIL rnd_miss[%0d] got=%b exp=%b", n, bus.ras_miss, m_miss); end
    end
  endtask

  initial begin
    test_reset();
    test_call_ret();
    test_nested();
    test_stall_redirect();
    test_trap();
    test_tail_call();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
